// File: rtl/piso_rr_scheduler_if.sv
// rtl/piso_rr_scheduler_if.sv - requester-side and serial-side signal bundle for piso_rr_scheduler
//
// Purpose: groups the frame request port and the serial output port.
// Ports (slave = scheduler side):
//   i_req_valid  NREQ            per-requester frame valid
//   i_req_data   NREQ*NDATA*BIT  frames, requester r word k at [(r*NDATA+k)*BIT +: BIT]
//   o_req_ready  NREQ            one-hot grant
//   o_valid      1               serial word valid
//   i_ready      1               downstream accept
//   o_data       BIT             serial word
//   o_src        SRC_W           source id of the frame being sent
//   o_first      1               word 0 marker
//   o_last       1               word NDATA-1 marker
interface piso_rr_scheduler_if #(
    parameter int BIT   = 8,
    parameter int NDATA = 3,
    parameter int NREQ  = 4,
    parameter int SRC_W = 2
);
    logic [NREQ-1:0]           i_req_valid;
    logic [NREQ*NDATA*BIT-1:0] i_req_data;
    logic [NREQ-1:0]           o_req_ready;
    logic                      o_valid;
    logic                      i_ready;
    logic [BIT-1:0]            o_data;
    logic [SRC_W-1:0]          o_src;
    logic                      o_first;
    logic                      o_last;

    modport slave (
        input  i_req_valid, i_req_data, i_ready,
        output o_req_ready, o_valid, o_data, o_src, o_first, o_last
    );

    modport master (
        output i_req_valid, i_req_data, i_ready,
        input  o_req_ready, o_valid, o_data, o_src, o_first, o_last
    );
endinterface

// File: rtl/piso_rr_scheduler.sv
// rtl/piso_rr_scheduler.sv - round-robin shared parallel-in/serial-out frame serializer
//
// Purpose: grants one of NREQ requesters, loads its NDATA-word frame into a
// shift buffer and emits it one word per accepted beat, tagged with source id
// and first/last markers.
// Ports:
//   i_clk    clock, all state on rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      piso_rr_scheduler_if.slave (request side + serial side)
module piso_rr_scheduler #(
    parameter int             BIT   = 8,
    parameter int             NDATA = 3,
    parameter int             NREQ  = 4,
    parameter int             SRC_W = 2,
    parameter logic [BIT-1:0] TAIL  = '0,
    parameter int             GAP   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    piso_rr_scheduler_if.slave   bus
);
    localparam int CNT_W = $clog2(NDATA);
    localparam int PTR_W = $clog2(NREQ);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDATA - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

    state_e                     state_q, state_d;
    logic [NDATA-1:0][BIT-1:0]  buf_q, buf_d;
    logic [SRC_W-1:0]           src_q, src_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [GAP_W-1:0]           gap_q, gap_d;
    logic [PTR_W-1:0]           ptr_q, ptr_d;

    logic                       win_any;
    logic [PTR_W-1:0]           win_idx;
    logic [PTR_W-1:0]           cand;
    logic                       last_word;
    logic                       grant;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            src_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            ptr_q   <= PTR_RST;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ptr_q   <= ptr_d;
        end
    end

    // Round-robin search starting one past the last winner
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % NREQ);
            if (!win_any && bus.i_req_valid[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign last_word = (state_q == S_SEND) && (cnt_q == CNT_LAST);

    // Grant opportunity: IDLE, or the accepted last word when frames may abut.
    // Gated by reset so no grant is shown while reset is held.
    assign grant = i_rst_n && win_any &&
                   ((state_q == S_IDLE) ||
                    ((GAP == 0) && last_word && bus.i_ready));

    // Next-state logic; a load takes priority over the shift
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        src_d   = src_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = S_SEND;
            src_d   = SRC_W'(win_idx);
            ptr_d   = win_idx;
            cnt_d   = '0;
            for (int k = 0; k < NDATA; k++) begin
                buf_d[k] = bus.i_req_data[(int'(win_idx) * NDATA + k) * BIT +: BIT];
            end
        end else begin
            case (state_q)
                S_SEND: begin
                    if (bus.i_ready) begin
                        for (int k = 0; k < NDATA - 1; k++) begin
                            buf_d[k] = buf_q[k+1];
                        end
                        buf_d[NDATA-1] = TAIL;
                        if (last_word) begin
                            cnt_d = '0;
                            if (GAP > 0) begin
                                state_d = S_GAP;
                                gap_d   = '0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; markers are qualified by valid so they never show outside SEND
    always_comb begin
        bus.o_valid     = (state_q == S_SEND);
        bus.o_data      = buf_q[0];
        bus.o_src       = src_q;
        bus.o_first     = (state_q == S_SEND) && (cnt_q == '0);
        bus.o_last      = last_word;
        bus.o_req_ready = grant ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;
    end
endmodule
